// File: rtl/mux_rr_arbiter_if.sv
// Channel bus of the round-robin mux arbiter: four requesters with data in,
// one-hot grant, selected index and muxed data out.
interface mux_rr_arbiter_if #(
    parameter int WIDTH = 4
);
    logic [3:0]       req;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] d;
    logic [3:0]       gnt;
    logic [1:0]       sel;
    logic             valid;
    logic [WIDTH-1:0] out;

    modport master (
        output req, a, b, c, d,
        input  gnt, sel, valid, out
    );

    modport slave (
        input  req, a, b, c, d,
        output gnt, sel, valid, out
    );
endinterface

// File: rtl/mux_rr_arbiter.sv
// Four-channel round-robin arbiter with registered one-hot grant and data mux.
// Define MUX_ARB_TIMEOUT_EN to limit a grant's tenure to MAX_HOLD cycles.
module mux_rr_arbiter #(
    parameter int WIDTH    = 4,
    parameter int MAX_HOLD = 4
) (
    input  logic              clk,
    input  logic              rst,
    mux_rr_arbiter_if.slave   bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [3:0]       r_gnt;
    logic [3:0]       w_gnt_next;
    logic [1:0]       r_sel;
    logic [1:0]       w_sel_next;
    logic [1:0]       r_ptr;
    logic [1:0]       w_ptr_next;
    logic             w_new_grant;
    logic             w_expire;
    logic             w_valid;
    logic [3:0]       w_others;
    logic [2:0]       w_pick_idle;
    logic [2:0]       w_pick_rel;
    logic [4*WIDTH-1:0] w_chan;
    logic [WIDTH-1:0] w_data [4];

    // Out-of-range tenure is rejected at elaboration by naming a missing module.
    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
        illegal_max_hold_parameter u_illegal ();
    end

    assign w_chan = {bus.d, bus.c, bus.b, bus.a};

    for (genvar gi = 0; gi < 4; gi++) begin : g_chan
        assign w_data[gi] = w_chan[gi*WIDTH +: WIDTH];
    end

    // Returns {found, index} of the first set bit of mask searching start, start+1, ...
    function automatic logic [2:0] rr_pick(input logic [3:0] mask, input logic [1:0] start);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            idx = start + 2'(i);
            if (mask[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    assign w_others    = bus.req & ~r_gnt;
    assign w_pick_idle = rr_pick(bus.req, r_ptr);
    assign w_pick_rel  = rr_pick(w_others, r_sel + 2'd1);

`ifdef MUX_ARB_TIMEOUT_EN
    logic [7:0] r_hold;
    logic [7:0] w_hold_next;

    assign w_expire = (r_hold == 8'(MAX_HOLD - 1));

    always_comb begin
        w_hold_next = r_hold + 8'd1;
        if (w_new_grant || r_state == IDLE || w_state_next == IDLE || w_expire) begin
            w_hold_next = 8'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold <= 8'd0;
        end else begin
            r_hold <= w_hold_next;
        end
    end
`else
    assign w_expire = 1'b0;
`endif

    always_comb begin
        w_state_next = r_state;
        w_gnt_next   = r_gnt;
        w_sel_next   = r_sel;
        w_ptr_next   = r_ptr;
        w_new_grant  = 1'b0;
        case (r_state)
            IDLE: begin
                w_gnt_next = 4'b0000;
                if (w_pick_idle[2]) begin
                    w_gnt_next   = 4'b0001 << w_pick_idle[1:0];
                    w_sel_next   = w_pick_idle[1:0];
                    w_state_next = GRANT;
                    w_new_grant  = 1'b1;
                end
            end
            GRANT: begin
                // A release or an expired tenure with a waiting rival both rotate past k.
                if (!bus.req[r_sel] || (w_expire && (|w_others))) begin
                    w_ptr_next = r_sel + 2'd1;
                    if (w_pick_rel[2]) begin
                        w_gnt_next  = 4'b0001 << w_pick_rel[1:0];
                        w_sel_next  = w_pick_rel[1:0];
                        w_new_grant = 1'b1;
                    end else begin
                        w_gnt_next   = 4'b0000;
                        w_state_next = IDLE;
                    end
                end
            end
            default: begin
                w_gnt_next   = 4'b0000;
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_gnt   <= 4'b0000;
            r_sel   <= 2'd0;
            r_ptr   <= 2'd0;
        end else begin
            r_state <= w_state_next;
            r_gnt   <= w_gnt_next;
            r_sel   <= w_sel_next;
            r_ptr   <= w_ptr_next;
        end
    end

    assign w_valid   = |r_gnt;
    assign bus.gnt   = r_gnt;
    assign bus.sel   = r_sel;
    assign bus.valid = w_valid;
    assign bus.out   = w_valid ? w_data[r_sel] : '0;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Scenario bench for mux_rr_arbiter; expectations are queued per driven cycle
// and popped after the following rising edge.
module tb_mux_rr_arbiter;

    localparam int WIDTH = 4;

    typedef struct {
        logic [3:0]       gnt;
        logic [1:0]       sel;
        logic             valid;
        logic [WIDTH-1:0] out;
    } exp_t;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;
    exp_t sb_q[$];

    mux_rr_arbiter_if #(.WIDTH(WIDTH)) bus_if ();

    mux_rr_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive req, queue the expected post-edge outputs (a..d = 1..4), advance one edge.
    task automatic step(input logic [3:0] r, input logic [3:0] eg, input logic [1:0] es);
        exp_t e;
        bus_if.req = r;
        e.gnt   = eg;
        e.sel   = es;
        e.valid = (eg != 4'b0000);
        e.out   = e.valid ? (WIDTH'(es) + 1'b1) : '0;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus_if.req = 4'b0000;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        #1;
        n_cmp++;
        if ({bus_if.gnt, bus_if.sel, bus_if.valid, bus_if.out} !== 11'd0) begin
            n_bad++;
            $display("FAIL reset_hold: got gnt=%b sel=%0d valid=%b out=%0d, want all zero",
                     bus_if.gnt, bus_if.sel, bus_if.valid, bus_if.out);
        end
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(4'b0000, 4'b0000, 2'd0);
            e = sb_q.pop_front();
            n_cmp++;
            $display("txn idle[%0d] gnt=%b sel=%0d valid=%b out=%0d", i, bus_if.gnt, bus_if.sel, bus_if.valid, bus_if.out);
            if ({bus_if.gnt, bus_if.sel, bus_if.valid, bus_if.out} !== {e.gnt, e.sel, e.valid, e.out}) begin
                n_bad++;
                $display("FAIL idle[%0d]: got gnt=%b sel=%0d valid=%b out=%0d, want gnt=%b sel=%0d valid=%b out=%0d",
                         i, bus_if.gnt, bus_if.sel, bus_if.valid, bus_if.out, e.gnt, e.sel, e.valid, e.out);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] rq [3] = '{4'b1010, 4'b1000, 4'b0000};
        logic [3:0] eg [3] = '{4'b0010, 4'b1000, 4'b0000};
        logic [1:0] es [3] = '{2'd1, 2'd3, 2'd3};
        exp_t e;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step(rq[i], eg[i], es[i]);
            e = sb_q.pop_front();
            n_cmp++;
            $display("txn b2b[%0d] req=%b gnt=%b sel=%0d valid=%b out=%0d", i, rq[i], bus_if.gnt, bus_if.sel, bus_if.valid, bus_if.out);
            if ({bus_if.gnt, bus_if.sel, bus_if.valid, bus_if.out} !== {e.gnt, e.sel, e.valid, e.out}) begin
                n_bad++;
                $display("FAIL b2b[%0d]: got gnt=%b sel=%0d valid=%b out=%0d, want gnt=%b sel=%0d valid=%b out=%0d",
                         i, bus_if.gnt, bus_if.sel, bus_if.valid, bus_if.out, e.gnt, e.sel, e.valid, e.out);
            end
        end
    endtask

    task automatic test_rr_order();
        logic [3:0] rq [6] = '{4'b1111, 4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1111};
        logic [3:0] eg [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0001};
        logic [1:0] es [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd0};
        exp_t e;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(rq[i], eg[i], es[i]);
            e = sb_q.pop_front();
            n_cmp++;
            $display("txn rr[%0d] req=%b gnt=%b sel=%0d valid=%b out=%0d", i, rq[i], bus_if.gnt, bus_if.sel, bus_if.valid, bus_if.out);
            if ({bus_if.gnt, bus_if.sel, bus_if.valid, bus_if.out} !== {e.gnt, e.sel, e.valid, e.out}) begin
                n_bad++;
                $display("FAIL rr[%0d]: got gnt=%b sel=%0d valid=%b out=%0d, want gnt=%b sel=%0d valid=%b out=%0d",
                         i, bus_if.gnt, bus_if.sel, bus_if.valid, bus_if.out, e.gnt, e.sel, e.valid, e.out);
            end
        end
    endtask

    task automatic test_other_req();
        logic [3:0] rq [5] = '{4'b0100, 4'b0111, 4'b1111, 4'b1011, 4'b0011};
        logic [3:0] eg [5] = '{4'b0100, 4'b0100, 4'b0100, 4'b1000, 4'b0001};
        logic [1:0] es [5] = '{2'd2, 2'd2, 2'd2, 2'd3, 2'd0};
        exp_t e;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(rq[i], eg[i], es[i]);
            e = sb_q.pop_front();
            n_cmp++;
            $display("txn other[%0d] req=%b gnt=%b sel=%0d valid=%b out=%0d", i, rq[i], bus_if.gnt, bus_if.sel, bus_if.valid, bus_if.out);
            if ({bus_if.gnt, bus_if.sel, bus_if.valid, bus_if.out} !== {e.gnt, e.sel, e.valid, e.out}) begin
                n_bad++;
                $display("FAIL other[%0d]: got gnt=%b sel=%0d valid=%b out=%0d, want gnt=%b sel=%0d valid=%b out=%0d",
                         i, bus_if.gnt, bus_if.sel, bus_if.valid, bus_if.out, e.gnt, e.sel, e.valid, e.out);
            end
        end
    endtask

    // Two requesters held: timeout build alternates every 4 cycles, default build never rotates.
    task automatic test_hold();
        exp_t       e;
        logic [1:0] ch;
        do_reset();
        for (int i = 0; i < 28; i++) begin
`ifdef MUX_ARB_TIMEOUT_EN
            ch = (i < 20) ? 2'((i / 4) % 2) : 2'd0;
`else
            ch = 2'd0;
`endif
            step((i < 20) ? 4'b0011 : 4'b0001, 4'b0001 << ch, ch);
            e = sb_q.pop_front();
            n_cmp++;
            $display("txn hold[%0d] gnt=%b sel=%0d valid=%b out=%0d", i, bus_if.gnt, bus_if.sel, bus_if.valid, bus_if.out);
            if ({bus_if.gnt, bus_if.sel, bus_if.valid, bus_if.out} !== {e.gnt, e.sel, e.valid, e.out}) begin
                n_bad++;
                $display("FAIL hold[%0d]: got gnt=%b sel=%0d valid=%b out=%0d, want gnt=%b sel=%0d valid=%b out=%0d",
                         i, bus_if.gnt, bus_if.sel, bus_if.valid, bus_if.out, e.gnt, e.sel, e.valid, e.out);
            end
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        do_reset();
        step(4'b0100, 4'b0100, 2'd2);
        e = sb_q.pop_front();
        n_cmp++;
        $display("txn arst_pre gnt=%b sel=%0d valid=%b out=%0d", bus_if.gnt, bus_if.sel, bus_if.valid, bus_if.out);
        if ({bus_if.gnt, bus_if.sel, bus_if.valid, bus_if.out} !== {e.gnt, e.sel, e.valid, e.out}) begin
            n_bad++;
            $display("FAIL arst_pre: got gnt=%b sel=%0d out=%0d, want gnt=%b sel=%0d out=%0d",
                     bus_if.gnt, bus_if.sel, bus_if.out, e.gnt, e.sel, e.out);
        end
        #2;
        rst = 1'b1;
        bus_if.req = 4'b1100;
        #1;
        n_cmp++;
        $display("txn arst_mid gnt=%b sel=%0d valid=%b out=%0d", bus_if.gnt, bus_if.sel, bus_if.valid, bus_if.out);
        if ({bus_if.gnt, bus_if.sel, bus_if.valid, bus_if.out} !== 11'd0) begin
            n_bad++;
            $display("FAIL arst_mid: got gnt=%b sel=%0d valid=%b out=%0d, want all zero",
                     bus_if.gnt, bus_if.sel, bus_if.valid, bus_if.out);
        end
        rst = 1'b0;
        step(4'b1100, 4'b0100, 2'd2);
        e = sb_q.pop_front();
        n_cmp++;
        $display("txn arst_post gnt=%b sel=%0d valid=%b out=%0d", bus_if.gnt, bus_if.sel, bus_if.valid, bus_if.out);
        if ({bus_if.gnt, bus_if.sel, bus_if.valid, bus_if.out} !== {e.gnt, e.sel, e.valid, e.out}) begin
            n_bad++;
            $display("FAIL arst_post: got gnt=%b sel=%0d out=%0d, want gnt=%b sel=%0d out=%0d",
                     bus_if.gnt, bus_if.sel, bus_if.out, e.gnt, e.sel, e.out);
        end
    endtask

    initial begin
        n_cmp      = 0;
        n_bad      = 0;
        rst        = 1'b1;
        bus_if.req = 4'b0000;
        bus_if.a   = 4'd1;
        bus_if.b   = 4'd2;
        bus_if.c   = 4'd3;
        bus_if.d   = 4'd4;
        test_reset();
        test_back_to_back();
        test_rr_order();
        test_other_req();
        test_hold();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
